// File: rtl/bellek_hakemi.sv
// bellek_hakemi -- two-port memory arbiter onto a single iomem bus.
//
// An instruction port (b_*, read-only) and a data port (v_*, read/write) share
// one iomem bus. The arbiter runs one bus transaction per grant. It returns to
// idle (BOSTA) for one cycle between grants.
//
// Handshake: a requester raises *_valid_i and holds it, with its address and
// data stable, until its *_ready_o strobe. *_ready_o is high for exactly one
// cycle and means "transaction done". *_rdata_o is meaningful only in that
// cycle. On the bus side, iomem_valid_o stays high with stable
// addr/wdata/wstrb until a cycle where iomem_ready_i is high. iomem_ready_i is
// ignored while nothing is granted.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   b_valid_i/b_addr_i      instruction request
//   b_ready_o/b_rdata_o     instruction completion strobe and read data
//   v_valid_i/v_addr_i/v_wstrb_i/v_wdata_i   data request (wstrb 0 = read)
//   v_ready_o/v_rdata_o     data completion strobe and read data
//   iomem_*                 shared bus (addr/wdata/wstrb registered at grant)
//   hata_o                  one-cycle pulse when a grant times out
//   durum_o                 current FSM state (0 BOSTA, 1 BUYRUK, 2 VERI)
//
// Parameter TIMEOUT_CYC: bus wait limit in grant cycles. 0 waits forever.
// Build option HAKEM_ROUND_ROBIN_EN: when it is defined, contention goes to
// the port not served last. When it is undefined, the data port always wins.
module bellek_hakemi #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        b_valid_i,
  input  logic [31:0] b_addr_i,
  output logic        b_ready_o,
  output logic [31:0] b_rdata_o,
  input  logic        v_valid_i,
  input  logic [31:0] v_addr_i,
  input  logic [3:0]  v_wstrb_i,
  input  logic [31:0] v_wdata_i,
  output logic        v_ready_o,
  output logic [31:0] v_rdata_o,
  output logic        iomem_valid_o,
  input  logic        iomem_ready_i,
  output logic [31:0] iomem_addr_o,
  output logic [31:0] iomem_wdata_o,
  output logic [3:0]  iomem_wstrb_o,
  input  logic [31:0] iomem_rdata_i,
  output logic        hata_o,
  output logic [1:0]  durum_o
);

  typedef enum logic [1:0] {
    BOSTA  = 2'd0,
    BUYRUK = 2'd1,
    VERI   = 2'd2
  } durum_t;

  localparam int SAYAC_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [SAYAC_W-1:0] SAYAC_SON =
    (TIMEOUT_CYC > 0) ? SAYAC_W'(TIMEOUT_CYC - 1) : '0;

  durum_t             durum, sonraki;
  logic [SAYAC_W-1:0] sayac;
  logic               zaman_asimi;
  logic               bitti;
  logic               v_kazanir;

`ifdef HAKEM_ROUND_ROBIN_EN
  // son_b = 1: the instruction port was served last, so the data port wins
  // the next contention.
  logic son_b;
  assign v_kazanir = son_b;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      son_b <= 1'b1;
    else if (bitti) son_b <= (durum == BUYRUK);
  end
`else
  assign v_kazanir = 1'b1;
`endif

  // A timeout fires in the cycle where the counter sits at its last value and
  // the bus still has not answered. If the bus answers in that same cycle,
  // the transaction completes normally instead.
  always_comb begin
    zaman_asimi = (TIMEOUT_CYC != 0) && (durum != BOSTA) &&
                  !iomem_ready_i && (sayac == SAYAC_SON);
    bitti       = (durum != BOSTA) && (iomem_ready_i || zaman_asimi);
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) durum <= BOSTA;
    else       durum <= sonraki;
  end

  // Next-state logic
  always_comb begin
    sonraki = durum;
    case (durum)
      BOSTA: begin
        if (v_valid_i && (v_kazanir || !b_valid_i)) sonraki = VERI;
        else if (b_valid_i)                         sonraki = BUYRUK;
      end
      BUYRUK, VERI: begin
        if (bitti) sonraki = BOSTA;
      end
      default: sonraki = BOSTA;
    endcase
  end

  // Output logic: the completion strobe and read data go only to the granted
  // port. A timed-out transaction returns zero data.
  always_comb begin
    b_ready_o = (durum == BUYRUK) && bitti;
    v_ready_o = (durum == VERI) && bitti;
    b_rdata_o = ((durum == BUYRUK) && iomem_ready_i) ? iomem_rdata_i : 32'h0;
    v_rdata_o = ((durum == VERI) && iomem_ready_i) ? iomem_rdata_i : 32'h0;
    hata_o    = zaman_asimi;
    durum_o   = durum;
  end

  // Bus request registers: the winner's fields are latched at the grant edge
  // and held until completion.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      iomem_valid_o <= 1'b0;
      iomem_addr_o  <= 32'h0;
      iomem_wdata_o <= 32'h0;
      iomem_wstrb_o <= 4'h0;
    end else if (durum == BOSTA) begin
      if (sonraki == VERI) begin
        iomem_valid_o <= 1'b1;
        iomem_addr_o  <= v_addr_i;
        iomem_wdata_o <= v_wdata_i;
        iomem_wstrb_o <= v_wstrb_i;
      end else if (sonraki == BUYRUK) begin
        iomem_valid_o <= 1'b1;
        iomem_addr_o  <= b_addr_i;
        iomem_wdata_o <= 32'h0;
        iomem_wstrb_o <= 4'h0;
      end
    end else if (bitti) begin
      iomem_valid_o <= 1'b0;
    end
  end

  // Wait counter. It is cleared while idle, so each grant starts from zero.
  // It stops at its last value, where the timeout ends the grant, so it
  // never wraps.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sayac <= '0;
    end else if (durum == BOSTA) begin
      sayac <= '0;
    end else if ((TIMEOUT_CYC != 0) && !iomem_ready_i && (sayac != SAYAC_SON)) begin
      sayac <= sayac + 1'b1;
    end
  end

endmodule

// File: doc/bellek_hakemi.md
BELLEK_HAKEMI -- requirements
Module: bellek_hakemi

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, iomem wait limit in cycles; 0 disables timeout.
REQ-002 clk_i  input  1  system clock; all state on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 b_valid_i  input  1  instruction-side (read-only) request; held until b_ready_o.
REQ-005 b_addr_i  input  32  instruction address.
REQ-006 b_ready_o  output  1  one-cycle completion strobe to instruction side.
REQ-007 b_rdata_o  output  32  instruction read data, valid with b_ready_o.
REQ-008 v_valid_i  input  1  data-side request; held until v_ready_o.
REQ-009 v_addr_i  input  32  data address.
REQ-010 v_wstrb_i  input  4  byte write strobes; 4'b0000 = read.
REQ-011 v_wdata_i  input  32  write data.
REQ-012 v_ready_o  output  1  one-cycle completion strobe to data side.
REQ-013 v_rdata_o  output  32  data read data, valid with v_ready_o.
REQ-014 iomem_valid_o  output  1  shared bus request.
REQ-015 iomem_ready_i  input  1  shared bus completion.
REQ-016 iomem_addr_o / iomem_wdata_o  output  32 each  registered bus address / write data.
REQ-017 iomem_wstrb_o  output  4  registered bus strobes; 4'b0000 for instruction grants.
REQ-018 iomem_rdata_i  input  32  bus read data.
REQ-019 hata_o  output  1  one-cycle timeout error pulse.

Function
REQ-020 FSM states BOSTA (idle), BUYRUK (instruction grant), VERI (data grant); one transaction per grant.
REQ-021 BOSTA: any valid sampled high -> grant at that edge; addr/wdata/wstrb of winner latched into iomem_*_o; iomem_valid_o=1 from next cycle.
REQ-022 BUYRUK/VERI: iomem_valid_o held 1, iomem_addr/wdata/wstrb_o stable until completion.
REQ-023 Completion: iomem_ready_i=1 in grant state -> granted ready_o=iomem_ready_i (combinational), rdata_o=iomem_rdata_i same cycle; next edge -> BOSTA, iomem_valid_o=0.
REQ-024 Non-granted ready_o SHALL stay 0; rdata_o of non-granted port = 32'h0.
REQ-025 Minimum transaction = 2 cycles (grant cycle + 1-cycle bus); back-to-back grants separated by one BOSTA cycle.
REQ-026 Simultaneous b_valid_i and v_valid_i in BOSTA resolved per REQ-036/037; loser remains pending, served next BOSTA.
REQ-027 iomem_ready_i while BOSTA SHALL be ignored.
REQ-028 Timeout counter: cleared on grant, +1 per grant-state cycle without iomem_ready_i; counter==TIMEOUT_CYC-1 without ready -> granted ready_o=1, rdata_o=32'h0, hata_o=1 that cycle; next edge BOSTA, iomem_valid_o=0.
REQ-029 Counter width = clog2(TIMEOUT_CYC+1); no wrap; TIMEOUT_CYC=0 -> counter disabled, waits indefinitely.
REQ-030 iomem_ready_i on the same cycle as timeout -> normal completion wins, hata_o=0.
REQ-031 Requester dropping valid mid-grant SHALL NOT abort bus transaction; completion strobe still issued.

Reset
REQ-032 rst_i=1 -> immediately: state BOSTA, iomem_valid_o=0, iomem_addr_o=0, iomem_wdata_o=0, iomem_wstrb_o=0, counter=0, last-served pointer=instruction.
REQ-033 During reset b_ready_o=v_ready_o=hata_o=0, rdata outputs 0.
REQ-034 Reset mid-transaction abandons it; no completion strobe issued for it.
REQ-035 First grant possible on first rising edge after rst_i deasserts.

Configuration
REQ-036 Macro HAKEM_ROUND_ROBIN_EN defined: on contention grant the port not served last; pointer updated at each completion or timeout.
REQ-037 Macro undefined: fixed priority, data side (v_) always wins contention; pointer logic absent.

Verification
REQ-038 Reset mid-VERI with iomem_valid_o=1 -> iomem_valid_o=0 same cycle, no v_ready_o; post-reset request served normally.
REQ-039 b_valid_i only, addr 0x0000_0100, ready after 3 cycles, rdata 0x0000_0013 -> iomem_wstrb_o=0, b_ready_o 1 cycle, b_rdata_o=0x0000_0013.
REQ-040 v write addr 0x2000_0004, wstrb 4'b0011, wdata 0xCAFE_BABE, ready 1 cycle later -> bus fields match, v_ready_o 1 cycle, b_ready_o=0.
REQ-041 Both valid continuously, ready always 1 -> with HAKEM_ROUND_ROBIN_EN grants alternate V,B,V,B...; without, V only while v_valid_i=1.
REQ-042 TIMEOUT_CYC=4, iomem_ready_i held 0 -> after 4 grant cycles v_ready_o=1, v_rdata_o=0, hata_o 1 cycle, iomem_valid_o=0 next cycle.
REQ-043 TIMEOUT_CYC=4, ready arrives exactly on 4th grant cycle -> normal completion, hata_o=0, rdata passed through.
